// File: rtl/chirp_proc_pkg.sv
// Shared chirp-processing types and default constants.
// Holds the sequencer state encoding and a saturating counter helper.
package chirp_proc_pkg;

   localparam int unsigned DEF_READ_RAM_WIDTH = 128;
   localparam int unsigned DEF_ADDR_WIDTH     = 14;
   localparam int unsigned DEF_RAM_RD_LAT     = 2;
   localparam int unsigned DEF_GAP_CYCLES     = 4;
   localparam int unsigned DEF_DRAIN_TIMEOUT  = 1023;
   localparam int unsigned CNT_W              = 10;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_GAP,
      ST_DONE
   } state_t;

   // Increment by one when en is set, holding at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/chirp_proc_delay.sv
// Fixed-depth register pipeline used to align read strobes with RAM data.
// Every stage clears on reset so in-flight strobes are discarded.
module chirp_proc_delay #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_bypass
      assign dout = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
         end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
         end
      end

      assign dout = pipe[DEPTH-1];
   end

endmodule

// File: rtl/chirp_proc_seq.sv
// Frame sequencer: reads row_cnt RAM rows per chirp, streams them to the
// chirp datapath, waits for the datapath to drain, then gaps before the next chirp.
module chirp_proc_seq
   import chirp_proc_pkg::*;
#(
   parameter int unsigned READ_RAM_WIDTH = DEF_READ_RAM_WIDTH,
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned RAM_RD_LAT     = DEF_RAM_RD_LAT,
   parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int unsigned DRAIN_TIMEOUT  = DEF_DRAIN_TIMEOUT
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   input  logic [ADDR_WIDTH-1:0]     i_base_addr,
   input  logic [CNT_W-1:0]          i_row_cnt,
   input  logic [CNT_W-1:0]          i_chirp_cnt,
   output logic                      o_ram_rd_en,
   output logic [ADDR_WIDTH-1:0]     o_ram_addr,
   input  logic [READ_RAM_WIDTH-1:0] i_ram_rdata,
   output logic [READ_RAM_WIDTH-1:0] o_x0,
   output logic                      o_x0_valid,
   output logic                      o_x0_last,
   input  logic                      i_y0_valid,
   output logic [CNT_W-1:0]          o_chirp_idx,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err
);

   localparam int unsigned TO_W  = $clog2(DRAIN_TIMEOUT + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [CNT_W-1:0]        row_cnt;
   logic [CNT_W-1:0]        chirp_cnt;
   logic [CNT_W-1:0]        row;
   logic [CNT_W-1:0]        y_cnt;
   logic [TO_W-1:0]         to_cnt;
   logic [GAP_W-1:0]        gap_cnt;
   logic                    rd_last;
   logic [1:0]              dly_out;
   logic                    start_ok;
   logic                    gap_end;
   logic                    last_chirp;
   logic                    issue_entry;
   logic                    drain_met;
   logic                    drain_to;

   assign start_ok    = (state == ST_IDLE) && i_start;
   assign gap_end     = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
   assign last_chirp  = (o_chirp_idx == chirp_cnt - CNT_W'(1));
   assign issue_entry = (start_ok && (i_row_cnt != '0) && (i_chirp_cnt != '0)) ||
                        (gap_end && !last_chirp);
   assign drain_met   = (y_cnt >= row_cnt);
   assign drain_to    = (to_cnt == TO_W'(DRAIN_TIMEOUT - 1));

   // Sequencer; addr_q walks linearly from the base across all chirps of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         row_cnt     <= '0;
         chirp_cnt   <= '0;
         row         <= '0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
         rd_last     <= 1'b0;
         o_ram_rd_en <= 1'b0;
         o_ram_addr  <= '0;
         o_chirp_idx <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_ram_rd_en <= 1'b0;
         rd_last     <= 1'b0;
         o_done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  addr_q      <= i_base_addr;
                  row_cnt     <= i_row_cnt;
                  chirp_cnt   <= i_chirp_cnt;
                  row         <= '0;
                  o_chirp_idx <= '0;
                  o_err       <= 1'b0;
                  o_busy      <= 1'b1;
                  state       <= issue_entry ? ST_ISSUE : ST_DONE;
               end
            end
            ST_ISSUE: begin
               o_ram_rd_en <= 1'b1;
               o_ram_addr  <= addr_q;
               addr_q      <= addr_q + ADDR_WIDTH'(1);
               row         <= row + CNT_W'(1);
               rd_last     <= (row == row_cnt - CNT_W'(1));
               if (row == row_cnt - CNT_W'(1)) begin
                  to_cnt <= '0;
                  state  <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_met || drain_to) begin
                  if (!drain_met) o_err <= 1'b1;
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  if (last_chirp) begin
                     state <= ST_DONE;
                  end else begin
                     o_chirp_idx <= o_chirp_idx + CNT_W'(1);
                     row         <= '0;
                     state       <= ST_ISSUE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            ST_DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath completions; a pulse on the entry edge belongs to the new chirp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_cnt <= '0;
      end else if (issue_entry) begin
         y_cnt <= CNT_W'(i_y0_valid);
      end else begin
         y_cnt <= sat_inc(y_cnt, i_y0_valid);
      end
   end

   chirp_proc_delay #(
      .DEPTH (RAM_RD_LAT),
      .WIDTH (2)
   ) u_rd_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({o_ram_rd_en, rd_last}),
      .dout  (dly_out)
   );

   // Capture RAM data in the cycle it is valid; adds the final stage of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_x0       <= '0;
         o_x0_valid <= 1'b0;
         o_x0_last  <= 1'b0;
      end else begin
         o_x0_valid <= dly_out[1];
         o_x0_last  <= dly_out[1] & dly_out[0];
         if (dly_out[1]) o_x0 <= i_ram_rdata;
      end
   end

endmodule

// File: tb/tb_chirp_proc_seq.sv
// Directed bench for chirp_proc_seq with a 2-cycle RAM model and a datapath
// model that returns a configurable number of y0 pulses per chirp.
module tb_chirp_proc_seq;

   logic          clk;
   logic          rst_n;
   logic          i_start;
   logic [13:0]   i_base_addr;
   logic [9:0]    i_row_cnt;
   logic [9:0]    i_chirp_cnt;
   logic          o_ram_rd_en;
   logic [13:0]   o_ram_addr;
   logic [127:0]  i_ram_rdata;
   logic [127:0]  o_x0;
   logic          o_x0_valid;
   logic          o_x0_last;
   logic          i_y0_valid;
   logic [9:0]    o_chirp_idx;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int y_limit = 0;
   int xrow    = 0;

   logic [13:0]  rd_addr_q [$];
   logic [9:0]   rd_idx_q  [$];
   int           rd_cyc_q  [$];
   logic [127:0] x0_q      [$];
   logic         x0_last_q [$];
   int           done_cyc_q[$];
   logic [13:0]  s1, s2;

   chirp_proc_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_row_cnt   (i_row_cnt),
      .i_chirp_cnt (i_chirp_cnt),
      .o_ram_rd_en (o_ram_rd_en),
      .o_ram_addr  (o_ram_addr),
      .i_ram_rdata (i_ram_rdata),
      .o_x0        (o_x0),
      .o_x0_valid  (o_x0_valid),
      .o_x0_last   (o_x0_last),
      .i_y0_valid  (i_y0_valid),
      .o_chirp_idx (o_chirp_idx),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic logic [127:0] pat(input logic [13:0] a);
      logic [127:0] v;
      for (int k = 0; k < 8; k++) v[k*16 +: 16] = {2'(k), (k < 4) ? a : ~a};
      return v;
   endfunction

   // RAM: data for the address strobed in cycle c is presented from cycle c+2.
   always @(negedge clk) begin
      i_ram_rdata = pat(s2);
      s2 = s1;
      s1 = o_ram_addr;
   end

   // Datapath: one y0 pulse per streamed row, up to y_limit rows per chirp.
   always @(negedge clk) begin
      if (!rst_n) begin
         xrow       = 0;
         i_y0_valid = 1'b0;
      end else begin
         i_y0_valid = o_x0_valid && (xrow < y_limit);
         if (o_x0_valid) xrow = o_x0_last ? 0 : xrow + 1;
      end
   end

   always @(negedge clk) begin
      if (o_ram_rd_en) begin
         rd_addr_q.push_back(o_ram_addr);
         rd_idx_q.push_back(o_chirp_idx);
         rd_cyc_q.push_back(cyc);
      end
      if (o_x0_valid) begin
         x0_q.push_back(o_x0);
         x0_last_q.push_back(o_x0_last);
      end
      if (o_done) done_cyc_q.push_back(cyc);
   end

   task automatic start_frame(input logic [13:0] b, input logic [9:0] r, input logic [9:0] c);
      @(negedge clk);
      i_base_addr = b;
      i_row_cnt   = r;
      i_chirp_cnt = c;
      i_start     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!o_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_timeout: no o_done within %0d cycles", name, budget);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({o_ram_rd_en, o_x0_valid, o_x0_last, o_busy, o_done, o_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000000",
                  {o_ram_rd_en, o_x0_valid, o_x0_last, o_busy, o_done, o_err});
      end
      vectors++;
      if (o_ram_addr !== 14'h0 || o_chirp_idx !== 10'h0 || o_x0 !== 128'h0) begin
         errors++;
         $display("FAIL reset_values: addr %h idx %h x0 %h want all 0", o_ram_addr, o_chirp_idx, o_x0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (o_busy !== 1'b0 || o_ram_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy %b rd_en %b want 0 0", o_busy, o_ram_rd_en);
      end
   endtask

   // Full frame with normal drain; optional repeated start while issuing.
   task automatic test_frame(input string name, input logic [13:0] base, input int rows,
                             input int chirps, input bit restart);
      int a0, x0, d0, n;
      logic [13:0] ea;
      a0 = rd_addr_q.size();
      x0 = x0_q.size();
      d0 = done_cyc_q.size();
      n  = rows * chirps;
      y_limit = rows;
      start_frame(base, 10'(rows), 10'(chirps));
      vectors++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy: got %b want 1", name, o_busy);
      end
      if (restart) begin
         i_start     = 1'b1;
         i_base_addr = 14'h0300;
         i_row_cnt   = 10'd1;
         i_chirp_cnt = 10'd5;
         repeat (3) @(negedge clk);
         i_start = 1'b0;
      end
      wait_done(name, 400);
      vectors++;
      if (rd_addr_q.size() - a0 != n) begin
         errors++;
         $display("FAIL %s read_count: got %0d want %0d", name, rd_addr_q.size() - a0, n);
      end
      vectors++;
      if (x0_q.size() - x0 != n) begin
         errors++;
         $display("FAIL %s x0_count: got %0d want %0d", name, x0_q.size() - x0, n);
      end
      for (int i = 0; i < n; i++) begin
         ea = 14'(int'(base) + i);
         if (a0 + i < rd_addr_q.size()) begin
            vectors++;
            if (rd_addr_q[a0+i] !== ea || rd_idx_q[a0+i] !== 10'(i / rows)) begin
               errors++;
               $display("FAIL %s read[%0d]: addr %h idx %0d want addr %h idx %0d",
                        name, i, rd_addr_q[a0+i], rd_idx_q[a0+i], ea, i / rows);
            end
         end
         if (x0 + i < x0_q.size()) begin
            vectors++;
            if (x0_q[x0+i] !== pat(ea) || x0_last_q[x0+i] !== ((i % rows) == rows - 1)) begin
               errors++;
               $display("FAIL %s x0[%0d]: data %h last %b want %h last %b", name, i,
                        x0_q[x0+i], x0_last_q[x0+i], pat(ea), (i % rows) == rows - 1);
            end
         end
         if (i > 0 && (i % rows) == 0 && a0 + i < rd_cyc_q.size()) begin
            vectors++;
            if (rd_cyc_q[a0+i] - rd_cyc_q[a0+i-1] - 1 < 4) begin
               errors++;
               $display("FAIL %s gap: got %0d idle cycles want >= 4", name,
                        rd_cyc_q[a0+i] - rd_cyc_q[a0+i-1] - 1);
            end
         end
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (done_cyc_q.size() - d0 != 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d want 1", name, done_cyc_q.size() - d0);
      end
      vectors++;
      if (o_err !== 1'b0 || o_busy !== 1'b0 || o_chirp_idx !== 10'(chirps - 1)) begin
         errors++;
         $display("FAIL %s end_state: err %b busy %b idx %0d want 0 0 %0d",
                  name, o_err, o_busy, o_chirp_idx, chirps - 1);
      end
   endtask

   task automatic test_drain_timeout();
      int a0, d0;
      a0 = rd_addr_q.size();
      d0 = done_cyc_q.size();
      y_limit = 2;
      start_frame(14'h0100, 10'd3, 10'd1);
      wait_done("timeout", 2000);
      vectors++;
      if (rd_addr_q.size() - a0 != 3 || done_cyc_q.size() - d0 != 1) begin
         errors++;
         $display("FAIL timeout_counts: reads %0d done %0d want 3 1",
                  rd_addr_q.size() - a0, done_cyc_q.size() - d0);
      end else begin
         vectors++;
         if (done_cyc_q[d0] - rd_cyc_q[a0+2] != 1028) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want 1028", done_cyc_q[d0] - rd_cyc_q[a0+2]);
         end
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err_sticky: got %b want 1", o_err);
      end
   endtask

   task automatic test_zero_count();
      int a0;
      a0 = rd_addr_q.size();
      start_frame(14'h0200, 10'd4, 10'd0);
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b1 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL zero_cycle1: done %b busy %b err %b want 0 1 0", o_done, o_busy, o_err);
      end
      @(negedge clk);
      vectors++;
      if (o_done !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_cycle2: done %b busy %b want 1 0", o_done, o_busy);
      end
      start_frame(14'h0200, 10'd0, 10'd3);
      @(negedge clk);
      vectors++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL zero_rows_done: got %b want 1", o_done);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (rd_addr_q.size() != a0) begin
         errors++;
         $display("FAIL zero_reads: got %0d want 0", rd_addr_q.size() - a0);
      end
   endtask

   task automatic test_reset_midframe();
      int n, x0, d0;
      y_limit = 4;
      start_frame(14'h0040, 10'd4, 10'd3);
      n = 0;
      while (!(o_chirp_idx == 10'd1 && o_ram_rd_en) && n < 200) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!(o_chirp_idx == 10'd1 && o_ram_rd_en)) begin
         errors++;
         $display("FAIL midrst_reach: idx %0d rd_en %b want 1 1", o_chirp_idx, o_ram_rd_en);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_ram_rd_en, o_x0_valid, o_x0_last, o_busy, o_done, o_err} !== 6'b0 ||
          o_ram_addr !== 14'h0 || o_chirp_idx !== 10'h0 || o_x0 !== 128'h0) begin
         errors++;
         $display("FAIL midrst_outputs: flags %b addr %h idx %0d want all 0",
                  {o_ram_rd_en, o_x0_valid, o_x0_last, o_busy, o_done, o_err}, o_ram_addr, o_chirp_idx);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      x0 = x0_q.size();
      d0 = done_cyc_q.size();
      repeat (8) @(negedge clk);
      vectors++;
      if (x0_q.size() != x0 || done_cyc_q.size() != d0) begin
         errors++;
         $display("FAIL midrst_flush: x0 %0d done %0d want 0 0", x0_q.size() - x0, done_cyc_q.size() - d0);
      end
      test_frame("post_rst", 14'h0050, 2, 2, 1'b0);
   endtask

   initial begin
      rst_n       = 1'b0;
      i_start     = 1'b0;
      i_base_addr = '0;
      i_row_cnt   = '0;
      i_chirp_cnt = '0;
      i_y0_valid  = 1'b0;
      i_ram_rdata = '0;
      s1          = '0;
      s2          = '0;
      test_reset();
      test_frame("basic", 14'h0010, 4, 2, 1'b0);
      test_frame("wrap", 14'h3FFE, 4, 1, 1'b0);
      test_drain_timeout();
      test_zero_count();
      test_frame("restart", 14'h0020, 4, 2, 1'b1);
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
